exp_taylor_pipe_stream: RTL and testbench

//  Parametrised, stallable Taylor-series e^x pipeline for the NPU activation path (softmax/logistic feed).

---
 rtl/exp_taylor_pipe_stream.sv | 166 ++++++++++++++++
 tb/tb_exp_taylor_pipe_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_taylor_pipe_stream.sv
// exp_taylor_pipe_stream
//   Stallable Taylor-series e^x pipeline, one sample per cycle, for the NPU
//   activation path. Input x is signed fixed point with a runtime integer-bit
//   count; the result is unsigned Q0.(DATA_W-1), clamped, with a saturation flag.
//
//   Build option: define EXP_ROUND_EN to round (half up) each term's rescale
//   shift instead of flooring it. Latency, handshake and clamping are the same
//   in both builds.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high; drops every in-flight sample
//   in_valid     input sample valid
//   in_ready     input accepted this cycle (combinational, = pipeline advance)
//   in_x         signed x, value = in_x / 2^(DATA_W-1-in_int_bits)
//   in_int_bits  integer bits of in_x, sampled with in_x
//   in_tag       sideband, returned unchanged on out_tag
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_exp      e^x, unsigned Q0.(DATA_W-1), clamped
//   out_tag      tag of this result
//   out_sat      out_exp was clamped
//
// Latency: NTERMS+2 advancing cycles (input capture, S0, S2..SNTERMS, output).
`timescale 1ns/1ps

module exp_taylor_pipe_stream #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NTERMS = 5,
   parameter int unsigned TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [3:0]        in_int_bits,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_exp,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_sat
);

   localparam int unsigned IW    = DATA_W + 16;   // internal word, headroom for int bits
   localparam int unsigned FRAC  = DATA_W - 1;
   localparam int unsigned PW    = 2 * IW + 16;   // term * xi * R at full width
   localparam int unsigned SHIFT = FRAC + 15;     // undo xi scale and R's 2^15 scale

   localparam logic signed [IW-1:0]     ONE     = IW'(1) << FRAC;
   localparam logic        [DATA_W-1:0] MAX_OUT = {1'b0, {(DATA_W-1){1'b1}}};
`ifdef EXP_ROUND_EN
   localparam logic signed [PW-1:0]     RND     = PW'(1) << (SHIFT - 1);
`else
   localparam logic signed [PW-1:0]     RND     = '0;
`endif

   // round(2^15 / k): multiplying by this and shifting by 15 divides by k
   function automatic logic signed [15:0] r_coef(input int unsigned k);
      case (k)
         2:       return 16'sd16384;
         3:       return 16'sd10923;
         4:       return 16'sd8192;
         5:       return 16'sd6554;
         6:       return 16'sd5461;
         7:       return 16'sd4681;
         default: return 16'sd4096;
      endcase
   endfunction

   logic adv;

   // input capture stage
   logic              v0;
   logic [DATA_W-1:0] x0;
   logic [3:0]        ib0;
   logic [TAG_W-1:0]  tag0;

   // term stages; index 1 is S0 (term1 = xi), index k holds term_k and partial sum
   logic                 sv    [1:NTERMS];
   logic signed [IW-1:0] sxi   [1:NTERMS];
   logic signed [IW-1:0] sterm [1:NTERMS];
   logic signed [IW-1:0] ssum  [1:NTERMS];
   logic [TAG_W-1:0]     stag  [1:NTERMS];

   logic signed [IW-1:0] xi0;
   logic signed [IW-1:0] sum0;
   logic signed [IW-1:0] term_nxt [2:NTERMS];
   logic [DATA_W-1:0]    exp_c;
   logic                 sat_c;

   // the whole pipe, output register included, moves only when the output slot frees
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // S0: scale x to Q(IW-FRAC).FRAC and seed sum = 1 + x
   always_comb begin
      xi0  = IW'(signed'(x0)) <<< ib0;
      sum0 = ONE + xi0;
   end

   // Sk: term_k = term_{k-1} * x / k
   always_comb begin
      for (int unsigned k = 2; k <= NTERMS; k++) begin
         term_nxt[k] = IW'((PW'(sterm[k-1]) * PW'(sxi[k-1]) * PW'(r_coef(k)) + RND) >>> SHIFT);
      end
   end

   // clamp final sum into unsigned Q0.FRAC; exactly 1.0 clamps to max
   always_comb begin
      exp_c = ssum[NTERMS][DATA_W-1:0];
      sat_c = 1'b0;
      if (ssum[NTERMS] >= ONE) begin
         exp_c = MAX_OUT;
         sat_c = 1'b1;
      end else if (ssum[NTERMS][IW-1]) begin
         exp_c = '0;
         sat_c = 1'b1;
      end
   end

   // valid chain and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         v0 <= 1'b0;
         for (int unsigned k = 1; k <= NTERMS; k++) begin
            sv[k] <= 1'b0;
         end
         out_valid <= 1'b0;
         out_exp   <= '0;
         out_tag   <= '0;
         out_sat   <= 1'b0;
      end else if (adv) begin
         v0    <= in_valid;
         sv[1] <= v0;
         for (int unsigned k = 2; k <= NTERMS; k++) begin
            sv[k] <= sv[k-1];
         end
         out_valid <= sv[NTERMS];
         out_exp   <= exp_c;
         out_tag   <= stag[NTERMS];
         out_sat   <= sat_c;
      end
   end

   // datapath registers; contents are qualified by the valid chain
   always_ff @(posedge clk) begin
      if (adv) begin
         x0       <= in_x;
         ib0      <= in_int_bits;
         tag0     <= in_tag;
         sxi[1]   <= xi0;
         sterm[1] <= xi0;
         ssum[1]  <= sum0;
         stag[1]  <= tag0;
         for (int unsigned k = 2; k <= NTERMS; k++) begin
            sxi[k]   <= sxi[k-1];
            sterm[k] <= term_nxt[k];
            ssum[k]  <= ssum[k-1] + term_nxt[k];
            stag[k]  <= stag[k-1];
         end
      end
   end

endmodule

// File: tb/tb_exp_taylor_pipe_stream.sv
// tb_exp_taylor_pipe_stream
//   Directed bench for exp_taylor_pipe_stream at DATA_W=32, NTERMS=5, TAG_W=8.
//   Hand-computed vectors plus a fixed-point reference model of the series,
//   with an in-order expectation queue for streamed traffic.
`timescale 1ns/1ps

module tb_exp_taylor_pipe_stream;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NTERMS = 5;
   localparam int unsigned TAG_W  = 8;

   typedef struct packed {
      logic [31:0] e;
      logic        s;
      logic [7:0]  t;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [3:0]        in_int_bits;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_exp;
   logic [TAG_W-1:0]  out_tag;
   logic              out_sat;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q[$];
   int   cyc      = 0;
   int   ov_count = 0;
   int   ov_first = -1;
   int   ov_last  = -1;
   logic        hold = 1'b0;
   logic [31:0] h_exp;
   logic        h_sat;
   logic [7:0]  h_tag;

   exp_taylor_pipe_stream #(
      .DATA_W(DATA_W),
      .NTERMS(NTERMS),
      .TAG_W (TAG_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_int_bits(in_int_bits),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_exp    (out_exp),
      .out_tag    (out_tag),
      .out_sat    (out_sat)
   );

   always #5 clk = ~clk;

   function automatic int r_of(input int k);
      case (k)
         2:       return 16384;
         3:       return 10923;
         4:       return 8192;
         5:       return 6554;
         6:       return 5461;
         7:       return 4681;
         default: return 4096;
      endcase
   endfunction

   // reference: series evaluated term by term in a loop
   function automatic exp_t model(input logic [31:0] x, input logic [3:0] ib, input logic [7:0] tg);
      logic signed [47:0]  xi;
      logic signed [47:0]  term;
      logic signed [47:0]  sum;
      logic signed [111:0] p;
      exp_t r;
      xi   = {{16{x[31]}}, x};
      xi   = xi <<< ib;
      term = xi;
      sum  = (48'sd1 <<< 31) + xi;
      for (int k = 2; k <= int'(NTERMS); k++) begin
         p = 112'(term) * 112'(xi) * 112'(r_of(k));
`ifdef EXP_ROUND_EN
         p = p + (112'sd1 <<< 45);
`endif
         p    = p >>> 46;
         term = p[47:0];
         sum  = sum + term;
      end
      r.t = tg;
      if (sum >= (48'sd1 <<< 31)) begin
         r.e = 32'h7FFF_FFFF;
         r.s = 1'b1;
      end else if (sum < 0) begin
         r.e = 32'h0;
         r.s = 1'b1;
      end else begin
         r.e = sum[31:0];
         r.s = 1'b0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // one clock of streamed traffic; called at the falling edge
   task automatic cycle(input logic v, input logic [31:0] x, input logic [3:0] ib,
                        input logic [7:0] tg, input logic ordy);
      exp_t got;
      exp_t want;
      in_valid    = v;
      in_x        = x;
      in_int_bits = ib;
      in_tag      = tg;
      out_ready   = ordy;
      #1;
      chk("in_ready_eq_adv", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold)
         chk("held_outputs", 64'({out_exp, out_sat, out_tag}), 64'({h_exp, h_sat, h_tag}));
      if (out_valid) begin
         ov_count++;
         if (ov_first < 0) ov_first = cyc;
         ov_last = cyc;
      end
      if (out_valid && out_ready) begin
         vectors++;
         assert (q.size() != 0)
         else begin
            miscompares++;
            $error("FAIL spurious_output: observed tag %0h, expected no output", out_tag);
         end
         if (q.size() != 0) begin
            want = q.pop_front();
            got  = '{e: out_exp, s: out_sat, t: out_tag};
            chk("stream_result", 64'(got), 64'(want));
         end
      end
      if (in_valid && in_ready) q.push_back(model(x, ib, tg));
      hold  = out_valid && !out_ready;
      h_exp = out_exp;
      h_sat = out_sat;
      h_tag = out_tag;
      cyc++;
      @(negedge clk);
   endtask

   // single sample through an otherwise empty pipe; lat counts edges from accept
   task automatic single(input logic [31:0] x, input logic [3:0] ib, input logic [7:0] tg,
                         output logic [31:0] e, output logic s, output logic [7:0] t,
                         output int lat);
      in_valid    = 1'b1;
      in_x        = x;
      in_int_bits = ib;
      in_tag      = tg;
      out_ready   = 1'b1;
      #1;
      chk("single_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      e = out_exp;
      s = out_sat;
      t = out_tag;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] e;
      logic        s;
      logic [7:0]  t;
      int          lat;
      int          ov_before;
      exp_t        m;
      longint      diff;

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_x        = '0;
      in_int_bits = '0;
      in_tag      = '0;
      out_ready   = 1'b0;

      // reset for three edges
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_exp", 64'(out_exp), 64'(0));
      chk("rst_out_sat", 64'(out_sat), 64'(0));
      chk("rst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk);

      // x = 0 -> exactly 1.0 -> clamped max code
      single(32'h0000_0000, 4'd0, 8'h5A, e, s, t, lat);
      chk("x0_latency", 64'(lat), 64'(7));
      chk("x0_exp", 64'(e), 64'(32'h7FFF_FFFF));
      chk("x0_sat", 64'(s), 64'(1));
      chk("x0_tag", 64'(t), 64'(8'h5A));

      // x = -0.5: truncated series vs e^-0.5 = 0x4DA2CBF2
      single(32'hC000_0000, 4'd0, 8'h11, e, s, t, lat);
      diff = longint'(e) - longint'(32'h4DA2_CBF2);
      if (diff < 0) diff = -diff;
      chk("m0p5_within_tol", 64'(diff <= 64'h1_0000), 64'(1));
      chk("m0p5_sat", 64'(s), 64'(0));
      m = model(32'hC000_0000, 4'd0, 8'h11);
      chk("m0p5_model", 64'({e, s, t}), 64'(m));
`ifndef EXP_ROUND_EN
      chk("m0p5_hand", 64'(e), 64'(32'h4DA2_1D44));
`endif

      // x = -1.0: 5-term series is 0x2EEEEEEF; the 10923 coefficient
      // (vs 32768/3) pulls the fixed-point result ~0x2667 below it
      single(32'hC000_0000, 4'd1, 8'h22, e, s, t, lat);
      diff = longint'(e) - longint'(32'h2EEE_EEEF);
      if (diff < 0) diff = -diff;
      chk("m1p0_within_tol", 64'(diff <= 64'h4000), 64'(1));
      chk("m1p0_sat", 64'(s), 64'(0));
      m = model(32'hC000_0000, 4'd1, 8'h22);
      chk("m1p0_model", 64'({e, s, t}), 64'(m));
`ifndef EXP_ROUND_EN
      chk("m1p0_hand", 64'(e), 64'(32'h2EEE_C888));
`endif

      // positive x clamps high
      single(32'h2000_0000, 4'd0, 8'h33, e, s, t, lat);
      chk("pos_exp", 64'(e), 64'(32'h7FFF_FFFF));
      chk("pos_sat", 64'(s), 64'(1));

      // x = -4: truncated series goes negative, clamps to zero
      single(32'h8000_0000, 4'd2, 8'h44, e, s, t, lat);
      chk("m4_exp", 64'(e), 64'(0));
      chk("m4_sat", 64'(s), 64'(1));

      // int_bits = 15: x = -2^-16, higher terms vanish
      single(32'hFFFF_FFFF, 4'd15, 8'h55, e, s, t, lat);
      chk("ib15_exp", 64'(e), 64'(32'h7FFF_8000));
      chk("ib15_sat", 64'(s), 64'(0));
      chk("ib15_tag", 64'(t), 64'(8'h55));

      // 16 back-to-back samples at full throughput
      ov_count = 0;
      ov_first = -1;
      ov_last  = -1;
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 32'h8000_0000 + 32'(i) * 32'h0800_0000, 4'(i % 3), 8'(i), 1'b1);
      repeat (12) cycle(1'b0, 32'h0, 4'd0, 8'h0, 1'b1);
      chk("b2b_count", 64'(ov_count), 64'(16));
      chk("b2b_contiguous", 64'(ov_last - ov_first), 64'(15));
      chk("b2b_drained", 64'(q.size()), 64'(0));

      // random backpressure
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom_range(0, 9) < 7), {1'b1, 31'($urandom)}, 4'($urandom_range(0, 2)),
               8'(100 + i), 1'($urandom_range(0, 1)));
      repeat (20) cycle(1'b0, 32'h0, 4'd0, 8'h0, 1'b1);
      chk("bp_drained", 64'(q.size()), 64'(0));

      // reset with four samples in flight
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'hD000_0000, 4'd0, 8'hE0 + 8'(i), 1'b1);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      rst = 1'b0;
      q.delete();
      hold      = 1'b0;
      ov_before = ov_count;
      repeat (12) cycle(1'b0, 32'h0, 4'd0, 8'h0, 1'b1);
      chk("flush_none_emerge", 64'(ov_count - ov_before), 64'(0));
      single(32'hE000_0000, 4'd0, 8'hA5, e, s, t, lat);
      chk("post_rst_latency", 64'(lat), 64'(7));
      m = model(32'hE000_0000, 4'd0, 8'hA5);
      chk("post_rst_result", 64'({e, s, t}), 64'(m));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
